// File: rtl/tick_sched_if.sv
// Configuration/status bundle for tick_sched: one valid/ready write port plus per-channel tick and busy.
interface tick_sched_if #(
  parameter int NCH = 4,
  parameter int CW  = 16,
  parameter int IW  = 2
);
  logic           cfg_valid;
  logic           cfg_ready;
  logic [IW-1:0]  cfg_ch;
  logic [CW-1:0]  cfg_period;
  logic           cfg_en;
  logic           cfg_oneshot;
  logic           cfg_err;
  logic [NCH-1:0] tick;
  logic [NCH-1:0] busy;

  modport master (
    output cfg_valid, cfg_ch, cfg_period, cfg_en, cfg_oneshot,
    input  cfg_ready, cfg_err, tick, busy
  );

  modport slave (
    input  cfg_valid, cfg_ch, cfg_period, cfg_en, cfg_oneshot,
    output cfg_ready, cfg_err, tick, busy
  );
endinterface

// File: rtl/tick_sched.sv
// Multi-channel tick scheduler: each channel emits a one-cycle clock-enable pulse every P cycles.
// Period changes are shadowed and take effect at the next reload so no period is ever truncated.
module tick_sched #(
  parameter int NCH = 4,
  parameter int CW  = 16,
  parameter int IW  = 2
) (
  input logic         clk,
  input logic         reset,
  tick_sched_if.slave bus
);
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  logic [NCH-1:0] state;
  logic [CW-1:0]  cnt [NCH];
  logic [CW-1:0]  act [NCH];
  logic [CW-1:0]  shd [NCH];
  logic [NCH-1:0] pend;
  logic [NCH-1:0] os;
  logic [NCH-1:0] tick_q;
  logic           ready_q;
  logic           err_q;

  logic           accept;
  logic           bad;
  logic           wr_ok;
  logic [NCH-1:0] sel;
  logic [CW-1:0]  p_m1;

  // NOTE: every signal gets a default at the top of always_comb so no path leaves it unassigned (no latch).
  always_comb begin
    sel    = '0;
    accept = bus.cfg_valid & ready_q;
    bad    = (bus.cfg_en && (bus.cfg_period == '0)) || (int'(bus.cfg_ch) >= NCH);
    wr_ok  = accept & ~bad;
    p_m1   = bus.cfg_period - 1'b1;
    for (int i = 0; i < NCH; i++) begin
      sel[i] = wr_ok && (int'(bus.cfg_ch) == i);
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every channel sees pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      ready_q <= 1'b0;
      err_q   <= 1'b0;
      state   <= '0;
      pend    <= '0;
      os      <= '0;
      tick_q  <= '0;
      // NOTE: the small per-channel register arrays are flops, not RAM, so they can and do take reset.
      for (int i = 0; i < NCH; i++) begin
        cnt[i] <= '0;
        act[i] <= '0;
        shd[i] <= '0;
      end
    end else begin
      ready_q <= 1'b1;
      err_q   <= accept & bad;
      for (int i = 0; i < NCH; i++) begin
        tick_q[i] <= 1'b0;
        if (sel[i] && !bus.cfg_en) begin
          // A stop wins over any reload due on this edge.
          state[i] <= ST_IDLE;
          cnt[i]   <= '0;
          pend[i]  <= 1'b0;
          os[i]    <= 1'b0;
        end else if (state[i] == ST_IDLE) begin
          if (sel[i]) begin
            state[i] <= ST_RUN;
            act[i]   <= bus.cfg_period;
            cnt[i]   <= p_m1;
            os[i]    <= bus.cfg_oneshot;
            pend[i]  <= 1'b0;
          end
        end else if (cnt[i] == '0) begin
          tick_q[i] <= 1'b1;
          if (sel[i]) begin
            // A write landing on the reload edge is used directly, never shadowed.
            act[i]  <= bus.cfg_period;
            cnt[i]  <= p_m1;
            os[i]   <= bus.cfg_oneshot;
            pend[i] <= 1'b0;
          end else if (os[i]) begin
            state[i] <= ST_IDLE;
            pend[i]  <= 1'b0;
          end else if (pend[i]) begin
            act[i]  <= shd[i];
            cnt[i]  <= shd[i] - 1'b1;
            pend[i] <= 1'b0;
          end else begin
            cnt[i] <= act[i] - 1'b1;
          end
        end else begin
          cnt[i] <= cnt[i] - 1'b1;
          if (sel[i]) begin
            shd[i]  <= bus.cfg_period;
            pend[i] <= 1'b1;
            os[i]   <= bus.cfg_oneshot;
          end
        end
      end
    end
  end

  assign bus.cfg_ready = ready_q;
  assign bus.cfg_err   = err_q;
  assign bus.tick      = tick_q;
  assign bus.busy      = state;
endmodule

// File: tb/tb_tick_sched.sv
// Self-checking bench for tick_sched: directed scenarios with literal expectations plus
// randomized writes compared every cycle against an absolute-time scheduling model.
module tb_tick_sched;
  localparam int NCH = 3;
  localparam int CW  = 8;
  localparam int IW  = 2;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  tick_sched_if #(.NCH(NCH), .CW(CW), .IW(IW)) bus ();
  tick_sched #(.NCH(NCH), .CW(CW), .IW(IW)) dut (.clk(clk), .reset(reset), .bus(bus.slave));

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, want, $time);
    end
  endtask

  // Model: each running channel knows the absolute edge number of its next tick.
  int             edge_n = 0;
  bit             m_run  [NCH];
  bit             m_pend [NCH];
  bit             m_os   [NCH];
  int             m_next [NCH];
  int             m_per  [NCH];
  int             m_shd  [NCH];
  logic [NCH-1:0] e_tick  = '0;
  logic [NCH-1:0] e_busy  = '0;
  logic           e_ready = 1'b0;
  logic           e_err   = 1'b0;
  bit             chk_on  = 1'b0;

  always @(posedge clk) begin
    bit acc, bad, wr;
    int p;
    edge_n++;
    chk_on = 1'b1;
    if (reset) begin
      e_ready = 1'b0;
      e_err   = 1'b0;
      e_tick  = '0;
      e_busy  = '0;
      for (int c = 0; c < NCH; c++) begin
        m_run[c]  = 1'b0;
        m_pend[c] = 1'b0;
      end
    end else begin
      acc = bus.cfg_valid && e_ready;
      p   = int'(bus.cfg_period);
      bad = (bus.cfg_en && p == 0) || (int'(bus.cfg_ch) >= NCH);
      e_err   = acc && bad;
      e_ready = 1'b1;
      for (int c = 0; c < NCH; c++) begin
        wr = acc && !bad && (int'(bus.cfg_ch) == c);
        e_tick[c] = 1'b0;
        if (wr && !bus.cfg_en) begin
          m_run[c] = 1'b0;
          m_pend[c] = 1'b0;
        end else if (!m_run[c]) begin
          if (wr) begin
            m_run[c]  = 1'b1;
            m_per[c]  = p;
            m_next[c] = edge_n + p;
            m_os[c]   = bus.cfg_oneshot;
            m_pend[c] = 1'b0;
          end
        end else if (edge_n == m_next[c]) begin
          e_tick[c] = 1'b1;
          if (wr) begin
            m_per[c]  = p;
            m_next[c] = edge_n + p;
            m_os[c]   = bus.cfg_oneshot;
            m_pend[c] = 1'b0;
          end else if (m_os[c]) begin
            m_run[c] = 1'b0;
          end else begin
            if (m_pend[c]) begin
              m_per[c]  = m_shd[c];
              m_pend[c] = 1'b0;
            end
            m_next[c] = edge_n + m_per[c];
          end
        end else if (wr) begin
          m_shd[c]  = p;
          m_pend[c] = 1'b1;
          m_os[c]   = bus.cfg_oneshot;
        end
        e_busy[c] = m_run[c];
      end
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      check("tick", 32'(bus.tick), 32'(e_tick));
      check("busy", 32'(bus.busy), 32'(e_busy));
      check("cfg_ready", 32'(bus.cfg_ready), 32'(e_ready));
      check("cfg_err", 32'(bus.cfg_err), 32'(e_err));
    end
  end

  task automatic idle_bus();
    bus.cfg_valid   = 1'b0;
    bus.cfg_ch      = '0;
    bus.cfg_period  = '0;
    bus.cfg_en      = 1'b0;
    bus.cfg_oneshot = 1'b0;
  endtask

  // Called just after a negedge; the write is accepted on the next posedge and the task
  // returns at the negedge that follows it.
  task automatic write(input int ch, input int p, input bit en, input bit os1);
    bus.cfg_valid   = 1'b1;
    bus.cfg_ch      = IW'(ch);
    bus.cfg_period  = CW'(p);
    bus.cfg_en      = en;
    bus.cfg_oneshot = os1;
    @(negedge clk);
    bus.cfg_valid = 1'b0;
  endtask

  task automatic wait_tick(input int ch);
    int k;
    k = 0;
    @(negedge clk);
    while (bus.tick[ch] !== 1'b1 && k < 400) begin
      @(negedge clk);
      k++;
    end
    check($sformatf("wait_tick%0d", ch), 32'(bus.tick[ch]), 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    int r;
    int cnt_cyc;
    idle_bus();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_ready", 32'(bus.cfg_ready), 32'd0);
    check("rst_tick", 32'(bus.tick), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    check("ready_up", 32'(bus.cfg_ready), 32'd1);

    // ch0 P=5: ticks 5, 10, 15 cycles after the accept edge
    write(0, 5, 1'b1, 1'b0);
    check("t1_busy", 32'(bus.busy), 32'b001);
    for (int j = 1; j <= 15; j++) begin
      @(negedge clk);
      check("t1_tick", 32'(bus.tick), (j % 5 == 0) ? 32'b001 : 32'b000);
    end

    // ch1 P=1 continuous, ch2 P=3 oneshot
    write(1, 1, 1'b1, 1'b0);
    write(2, 3, 1'b1, 1'b1);
    check("t2_tick1_on", 32'(bus.tick[1]), 32'd1);
    check("t2_busy2", 32'(bus.busy[2]), 32'd1);
    for (int j = 1; j <= 6; j++) begin
      @(negedge clk);
      check("t2_tick1", 32'(bus.tick[1]), 32'd1);
      check("t2_tick2", 32'(bus.tick[2]), (j == 3) ? 32'd1 : 32'd0);
      check("t2_busy2_drop", 32'(bus.busy[2]), (j < 3) ? 32'd1 : 32'd0);
    end
    write(1, 0, 1'b0, 1'b0);
    check("t2_stop_err", 32'(bus.cfg_err), 32'd0);
    check("t2_stop_tick1", 32'(bus.tick[1]), 32'd0);
    check("t2_stop_busy1", 32'(bus.busy[1]), 32'd0);

    // ch0 P=8, change to 3 two cycles after a tick: next tick still 8 after the previous
    write(0, 0, 1'b0, 1'b0);
    write(0, 8, 1'b1, 1'b0);
    wait_tick(0);
    @(negedge clk);
    write(0, 3, 1'b1, 1'b0);
    for (int j = 1; j <= 6; j++) begin
      @(negedge clk);
      check("t3_hold8", 32'(bus.tick[0]), (j == 6) ? 32'd1 : 32'd0);
    end
    for (int j = 1; j <= 6; j++) begin
      @(negedge clk);
      check("t3_new3", 32'(bus.tick[0]), (j % 3 == 0) ? 32'd1 : 32'd0);
    end
    // Back to 8, then write 3 exactly on a reload edge
    write(0, 8, 1'b1, 1'b0);
    wait_tick(0);
    repeat (7) @(negedge clk);
    write(0, 3, 1'b1, 1'b0);
    check("t3_reload_tick", 32'(bus.tick[0]), 32'd1);
    for (int j = 1; j <= 6; j++) begin
      @(negedge clk);
      check("t3_reload3", 32'(bus.tick[0]), (j % 3 == 0) ? 32'd1 : 32'd0);
    end

    // Rejected writes and a harmless stop of an idle channel
    write(1, 0, 1'b1, 1'b0);
    check("t4_p0_err", 32'(bus.cfg_err), 32'd1);
    check("t4_p0_busy", 32'(bus.busy[1]), 32'd0);
    check("t4_p0_tick", 32'(bus.tick[1]), 32'd0);
    @(negedge clk);
    check("t4_err_pulse", 32'(bus.cfg_err), 32'd0);
    write(3, 4, 1'b1, 1'b0);
    check("t4_ch_err", 32'(bus.cfg_err), 32'd1);
    check("t4_ch_busy", 32'(bus.busy[2:1]), 32'd0);
    @(negedge clk);
    check("t4_err_pulse2", 32'(bus.cfg_err), 32'd0);
    write(1, 7, 1'b0, 1'b0);
    check("t4_idle_stop_err", 32'(bus.cfg_err), 32'd0);
    check("t4_idle_stop_busy", 32'(bus.busy[1]), 32'd0);

    // ch2 P=4 stopped on its reload edge: no tick
    write(2, 4, 1'b1, 1'b0);
    wait_tick(2);
    repeat (3) @(negedge clk);
    write(2, 4, 1'b0, 1'b0);
    check("t5_stop_tick", 32'(bus.tick[2]), 32'd0);
    check("t5_stop_busy", 32'(bus.busy[2]), 32'd0);
    for (int j = 1; j <= 6; j++) begin
      @(negedge clk);
      check("t5_quiet", 32'(bus.tick[2]), 32'd0);
    end

    // Largest period, oneshot: first tick exactly 255 cycles after accept
    write(1, 255, 1'b1, 1'b1);
    cnt_cyc = 0;
    while (bus.tick[1] !== 1'b1 && cnt_cyc < 300) begin
      @(negedge clk);
      cnt_cyc++;
    end
    check("t6_maxp_delay", 32'(cnt_cyc), 32'd255);

    // Reset in the middle of activity on all channels
    write(1, 2, 1'b1, 1'b0);
    write(2, 1, 1'b1, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("t7_rst_tick", 32'(bus.tick), 32'd0);
    check("t7_rst_busy", 32'(bus.busy), 32'd0);
    check("t7_rst_ready", 32'(bus.cfg_ready), 32'd0);
    @(negedge clk);
    check("t7_rst_ready2", 32'(bus.cfg_ready), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    check("t7_ready_back", 32'(bus.cfg_ready), 32'd1);
    check("t7_busy_clear", 32'(bus.busy), 32'd0);

    // Randomized traffic, checked every cycle against the model
    for (int cyc = 0; cyc < 4000; cyc++) begin
      reset = ($urandom_range(0, 599) == 0);
      if ($urandom_range(0, 2) == 0) begin
        bus.cfg_valid = 1'b1;
        bus.cfg_ch    = IW'($urandom_range(0, 3));
        r = int'($urandom_range(0, 15));
        if (r == 0)      bus.cfg_period = '0;
        else if (r == 1) bus.cfg_period = CW'(255);
        else if (r < 6)  bus.cfg_period = CW'($urandom_range(1, 3));
        else             bus.cfg_period = CW'($urandom_range(1, 20));
        bus.cfg_en      = ($urandom_range(0, 4) != 0);
        bus.cfg_oneshot = ($urandom_range(0, 3) == 0);
      end else begin
        bus.cfg_valid = 1'b0;
      end
      @(negedge clk);
    end
    reset = 1'b0;
    idle_bus();
    repeat (5) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
